writeback_unit: RTL
===================

WRITEBACK_UNIT -- requirements
Module: writeback_unit

Interface
REQ-001 Parameter DATA_WIDTH, default 32, register/result width; legal values 32 or 64.
REQ-002 Parameter NUM_SOURCES, default 4, number of result sources; minimum 2. SW = clog2(NUM_SOURCES).
REQ-003 Parameter LOAD_SRC, default 1, source index that selects extended load data instead of ResultInputsM.
REQ-004 Parameter BW = clog2(DATA_WIDTH/8), byte-offset width.
REQ-005 clk  in  1  clock, rising edge.
REQ-006 rst_n  in  1  reset, asynchronous, active-low.
REQ-007 ValidM  in  1  instruction presented for writeback this cycle.
REQ-008 RegWriteM  in  1  instruction writes the register file.
REQ-009 RdM  in  5  destination register.
REQ-010 ResultSrcM  in  SW  result source select.
REQ-011 ResultInputsM  in  NUM_SOURCES*DATA_WIDTH  packed sources; source k at bits [k*DATA_WIDTH +: DATA_WIDTH].
REQ-012 Funct3M  in  3  load type: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU, 011 LD (DATA_WIDTH=64), 110 LWU (DATA_WIDTH=64).
REQ-013 ByteOffsetM  in  BW  low address bits of the load.
REQ-014 ReadDataW  in  DATA_WIDTH  raw memory read word.
REQ-015 ReadValidW  in  1  ReadDataW valid this cycle.
REQ-016 StallW  out  1  upstream must hold ValidM and all *M inputs stable.
REQ-017 RegWriteW  out  1  register file write enable, registered.
REQ-018 RdW  out  5  register file write address, registered.
REQ-019 ResultW  out  DATA_WIDTH  register file write data, registered.
REQ-020 RetireCountW  out  64  retired instruction count.

Function
REQ-021 FSM states IDLE and WAIT_LOAD; StallW is combinational: 1 in WAIT_LOAD while ReadValidW=0, otherwise 0.
REQ-022 IDLE, ValidM=1, ResultSrcM!=LOAD_SRC: select source ResultSrcM, register it on the next edge; stay IDLE.
REQ-023 IDLE, ValidM=1, ResultSrcM=LOAD_SRC, ReadValidW=1: complete the load in the same cycle; stay IDLE.
REQ-024 IDLE, ValidM=1, ResultSrcM=LOAD_SRC, ReadValidW=0: capture RdM, RegWriteM, Funct3M, ByteOffsetM; go to WAIT_LOAD.
REQ-025 WAIT_LOAD, ReadValidW=1: complete the load using the captured fields; go to IDLE; StallW=0 in that cycle.
REQ-026 WAIT_LOAD ignores ValidM; the held instruction is accepted in the cycle after the load completes.
REQ-027 Completion (REQ-022/023/025) registers RegWriteW = captured RegWrite AND (Rd!=0), RdW, and ResultW on the next edge. All three are valid for exactly one cycle; RegWriteW=0 otherwise.
REQ-028 Latency: one cycle from acceptance or ReadValidW to RegWriteW.
REQ-029 ResultSrcM >= NUM_SOURCES selects all-zero data.
REQ-030 Load extension: byte lane = ByteOffset; half lane = ByteOffset[BW-1:1]; word lane = ByteOffset[BW-1:2]; sign-extend LB/LH/LW; zero-extend LBU/LHU/LWU; LD passes through.
REQ-031 Unlisted Funct3 values pass ReadDataW through unmodified.
REQ-032 ReadValidW while in IDLE with no load presented is ignored.
REQ-033 When RegWriteW is 0, ResultW and RdW hold their previous values.
REQ-034 RetireCountW increments by 1 on every completion, including Rd=0 and RegWrite=0. It wraps from 2^64-1 to 0.

Reset
REQ-035 rst_n=0 asynchronously forces: state IDLE, RegWriteW=0, RdW=0, ResultW=0, RetireCountW=0, captured fields 0, StallW=0.
REQ-036 Reset during WAIT_LOAD drops the pending load; no write occurs after reset release.
REQ-037 Reset release is synchronous to clk; the first acceptance can occur on the first rising edge after release.

Verification
REQ-038 ALU op: ValidM=1, ResultSrcM=0, source0=0x1234_5678, RdM=5 -> next cycle RegWriteW=1, RdW=5, ResultW=0x1234_5678, RetireCountW=1.
REQ-039 Immediate load: LB, ByteOffsetM=2, ReadDataW=0x0080_0000, ReadValidW=1 -> ResultW=0xFFFF_FF80; LBU with the same inputs -> 0x0000_0080.
REQ-040 Delayed load: LH, offset 2, RdM=7, ReadValidW low 3 cycles, then 0x8001_0000 -> StallW=1 for 3 cycles, then RegWriteW=1, RdW=7, ResultW=0xFFFF_8001.
REQ-041 Rd=0: RegWriteM=1, RdM=0 -> RegWriteW=0 and RetireCountW increments. ResultSrcM=3 with NUM_SOURCES=3 -> ResultW=0.
REQ-042 Reset mid-wait: enter WAIT_LOAD, assert rst_n=0, release, then pulse ReadValidW -> no RegWriteW, RetireCountW=0, StallW=0.
REQ-043 Wrap: preload RetireCountW to 2^64-1 via back-door force, retire one instruction -> RetireCountW=0.

Source files
------------

// File: rtl/writeback_unit_if.sv
// Writeback-stage bundle: memory-stage instruction fields, load read-data return,
// and the registered register-file write port.
interface writeback_unit_if #(
    parameter int unsigned DATA_WIDTH  = 32,
    parameter int unsigned NUM_SOURCES = 4
);
    localparam int unsigned SW = (NUM_SOURCES > 1) ? $clog2(NUM_SOURCES) : 1;
    localparam int unsigned BW = $clog2(DATA_WIDTH / 8);

    logic                              ValidM;
    logic                              RegWriteM;
    logic [4:0]                        RdM;
    logic [SW-1:0]                     ResultSrcM;
    logic [NUM_SOURCES*DATA_WIDTH-1:0] ResultInputsM;
    logic [2:0]                        Funct3M;
    logic [BW-1:0]                     ByteOffsetM;
    logic [DATA_WIDTH-1:0]             ReadDataW;
    logic                              ReadValidW;
    logic                              StallW;
    logic                              RegWriteW;
    logic [4:0]                        RdW;
    logic [DATA_WIDTH-1:0]             ResultW;
    logic [63:0]                       RetireCountW;

    modport master (
        output ValidM, RegWriteM, RdM, ResultSrcM, ResultInputsM, Funct3M, ByteOffsetM,
        output ReadDataW, ReadValidW,
        input  StallW, RegWriteW, RdW, ResultW, RetireCountW
    );

    modport slave (
        input  ValidM, RegWriteM, RdM, ResultSrcM, ResultInputsM, Funct3M, ByteOffsetM,
        input  ReadDataW, ReadValidW,
        output StallW, RegWriteW, RdW, ResultW, RetireCountW
    );
endinterface

// File: rtl/writeback_unit.sv
// Writeback stage: selects the result source, extends load data, waits for late
// load data, and drives a registered register-file write port plus a retire counter.
module writeback_unit #(
    parameter int unsigned DATA_WIDTH  = 32,
    parameter int unsigned NUM_SOURCES = 4,
    parameter int unsigned LOAD_SRC    = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    writeback_unit_if.slave wb
);
    localparam int unsigned SW = (NUM_SOURCES > 1) ? $clog2(NUM_SOURCES) : 1;
    localparam int unsigned BW = $clog2(DATA_WIDTH / 8);

    typedef enum logic [0:0] {StIdle, StWaitLoad} state_e;

    state_e                state_q;
    logic                  cap_we_q;
    logic [4:0]            cap_rd_q;
    logic [2:0]            cap_f3_q;
    logic [BW-1:0]         cap_off_q;
    logic                  reg_write_q;
    logic [4:0]            rd_q;
    logic [DATA_WIDTH-1:0] result_q;
    logic [63:0]           retire_count_q;

    logic                  complete;
    logic                  capture;
    state_e                state_d;
    logic                  fin_we;
    logic [4:0]            fin_rd;
    logic [DATA_WIDTH-1:0] fin_data;
    logic [DATA_WIDTH-1:0] src_data;

    // Lanes are picked by masking the offset down to the access alignment.
    function automatic logic [DATA_WIDTH-1:0] extend(input logic [DATA_WIDTH-1:0] data,
                                                     input logic [2:0]            f3,
                                                     input logic [BW-1:0]         off);
        logic [BW-1:0]         h_off;
        logic [BW-1:0]         w_off;
        logic [DATA_WIDTH-1:0] b_sh;
        logic [DATA_WIDTH-1:0] h_sh;
        logic [DATA_WIDTH-1:0] w_sh;
        h_off = off & ~BW'(1);
        w_off = off & ~BW'(3);
        b_sh  = data >> {off, 3'b000};
        h_sh  = data >> {h_off, 3'b000};
        w_sh  = data >> {w_off, 3'b000};
        case (f3)
            3'b000:  extend = DATA_WIDTH'($signed(b_sh[7:0]));
            3'b001:  extend = DATA_WIDTH'($signed(h_sh[15:0]));
            3'b010:  extend = DATA_WIDTH'($signed(w_sh[31:0]));
            3'b100:  extend = DATA_WIDTH'(b_sh[7:0]);
            3'b101:  extend = DATA_WIDTH'(h_sh[15:0]);
            3'b110:  extend = DATA_WIDTH'(w_sh[31:0]);
            default: extend = data;
        endcase
    endfunction

    always_comb begin
        src_data = '0;
        for (int k = 0; k < NUM_SOURCES; k++) begin
            if (wb.ResultSrcM == SW'(k)) src_data = wb.ResultInputsM[k*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    always_comb begin
        complete = 1'b0;
        capture  = 1'b0;
        state_d  = state_q;
        fin_we   = wb.RegWriteM;
        fin_rd   = wb.RdM;
        fin_data = '0;
        case (state_q)
            StIdle: begin
                if (wb.ValidM) begin
                    if (wb.ResultSrcM != SW'(LOAD_SRC)) begin
                        complete = 1'b1;
                        fin_data = src_data;
                    end else if (wb.ReadValidW) begin
                        complete = 1'b1;
                        fin_data = extend(wb.ReadDataW, wb.Funct3M, wb.ByteOffsetM);
                    end else begin
                        capture = 1'b1;
                        state_d = StWaitLoad;
                    end
                end
            end
            StWaitLoad: begin
                fin_we = cap_we_q;
                fin_rd = cap_rd_q;
                if (wb.ReadValidW) begin
                    complete = 1'b1;
                    fin_data = extend(wb.ReadDataW, cap_f3_q, cap_off_q);
                    state_d  = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= StIdle;
            cap_we_q       <= 1'b0;
            cap_rd_q       <= '0;
            cap_f3_q       <= '0;
            cap_off_q      <= '0;
            reg_write_q    <= 1'b0;
            rd_q           <= '0;
            result_q       <= '0;
            retire_count_q <= '0;
        end else begin
            state_q     <= state_d;
            reg_write_q <= complete && fin_we && (fin_rd != 5'd0);
            if (capture) begin
                cap_we_q  <= wb.RegWriteM;
                cap_rd_q  <= wb.RdM;
                cap_f3_q  <= wb.Funct3M;
                cap_off_q <= wb.ByteOffsetM;
            end
            // Rd/result only move with a real write so they hold while the enable is low.
            if (complete && fin_we && (fin_rd != 5'd0)) begin
                rd_q     <= fin_rd;
                result_q <= fin_data;
            end
            if (complete) retire_count_q <= retire_count_q + 64'd1;
        end
    end

    assign wb.StallW       = (state_q == StWaitLoad) && !wb.ReadValidW;
    assign wb.RegWriteW    = reg_write_q;
    assign wb.RdW          = rd_q;
    assign wb.ResultW      = result_q;
    assign wb.RetireCountW = retire_count_q;
endmodule
